frame_capture: RTL and testbench

Frame capture writer for the HDR display path. Accepts a camera-style pixel stream (frame/line/pixel valid qualifiers), crops it to the 640×480 display window, buffers pixels in a small FIFO, and writes them to SRAM through a request/acknowledge port. Frames are stored linearly at addresses 0..307199, one 16-bit word per pixel, in the same layout the VGA display controller reads back.

---
 rtl/frame_capture.sv | 152 +++++++++++++++
 tb/tb_frame_capture.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture.sv
// Crops a camera pixel stream to an H_ACT x V_ACT window and writes it linearly to SRAM via a small FIFO.
// Define CAPTURE_DECIMATE_EN for 2x2 decimation of a 2*H_ACT x 2*V_ACT sensor.
module frame_capture #(
   parameter int H_ACT      = 640,
   parameter int V_ACT      = 480,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        i_clk_25M,
   input  logic        i_rst_n,
   input  logic        i_start_capture,
   input  logic        i_frame_valid,
   input  logic        i_line_valid,
   input  logic        i_pix_valid,
   input  logic [15:0] i_pix_data,
   output logic [19:0] o_addr_capture,
   output logic [15:0] o_pixel_value,
   output logic        o_wr_req,
   input  logic        i_wr_ack,
   output logic        o_capturing,
   output logic        o_done,
   output logic        o_overflow
);

`ifdef CAPTURE_DECIMATE_EN
   localparam int X_LIM = 2 * H_ACT;
   localparam int Y_LIM = 2 * V_ACT;
`else
   localparam int X_LIM = H_ACT;
   localparam int Y_LIM = V_ACT;
`endif
   localparam int CNT_W = $clog2((H_ACT > V_ACT ? H_ACT : V_ACT) * 4);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [19:0] ADDR_MAX = 20'(H_ACT * V_ACT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DRAIN} state_t;

   state_t state, state_nxt;
   logic frame_valid_p1, line_valid_p1;
   logic fv_rise, fv_fall, lv_fall;
   logic clear_ctx, counting_en, qualified, in_window, accept;
   logic [CNT_W-1:0] x_cnt, y_cnt;
   logic [15:0] mem [FIFO_DEPTH];
   logic [PTR_W:0] wr_ptr, rd_ptr;
   logic fifo_empty, fifo_full, push_ok, pop, drop;

   // Counters saturate so oversized lines/frames can never wrap back into the window.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign fv_rise = i_frame_valid & ~frame_valid_p1;
   assign fv_fall = ~i_frame_valid & frame_valid_p1;
   assign lv_fall = ~i_line_valid & line_valid_p1;

   // Accept in the ARM cycle that sees the frame rise so a pixel coincident with it is not lost.
   assign counting_en = (state == S_CAPTURE) | ((state == S_ARM) & fv_rise);
   assign qualified   = i_frame_valid & i_line_valid & i_pix_valid;
`ifdef CAPTURE_DECIMATE_EN
   assign in_window   = (x_cnt < CNT_W'(X_LIM)) & (y_cnt < CNT_W'(Y_LIM)) & ~x_cnt[0] & ~y_cnt[0];
`else
   assign in_window   = (x_cnt < CNT_W'(X_LIM)) & (y_cnt < CNT_W'(Y_LIM));
`endif
   assign accept      = counting_en & qualified & in_window;

   assign fifo_empty    = (wr_ptr == rd_ptr);
   assign fifo_full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                          (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign o_wr_req      = ~fifo_empty;
   assign o_pixel_value = fifo_empty ? 16'd0 : mem[rd_ptr[PTR_W-1:0]];
   assign pop           = o_wr_req & i_wr_ack;
   assign push_ok       = accept & (~fifo_full | pop);
   assign drop          = accept & fifo_full & ~pop;

   always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= S_IDLE;
         frame_valid_p1 <= 1'b0;
         line_valid_p1  <= 1'b0;
      end else begin
         state          <= state_nxt;
         frame_valid_p1 <= i_frame_valid;
         line_valid_p1  <= i_line_valid;
      end
   end

   always_comb begin
      state_nxt   = state;
      clear_ctx   = 1'b0;
      o_done      = 1'b0;
      o_capturing = (state != S_IDLE);
      case (state)
         S_IDLE: if (i_start_capture) begin
            state_nxt = S_ARM;
            clear_ctx = 1'b1;
         end
         S_ARM:     if (fv_rise) state_nxt = S_CAPTURE;
         S_CAPTURE: if (fv_fall) state_nxt = S_DRAIN;
         S_DRAIN: if (fifo_empty) begin
            o_done    = 1'b1;
            state_nxt = S_IDLE;
         end
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
      if (!i_rst_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (clear_ctx) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (counting_en) begin
         if (lv_fall) begin
            x_cnt <= '0;
            if (x_cnt != '0) y_cnt <= sat_inc(y_cnt);
         end else if (qualified) begin
            x_cnt <= sat_inc(x_cnt);
         end
      end
   end

   // ---- write buffer: storage holds data only, pointers carry the state ----
   always_ff @(posedge i_clk_25M) begin
      if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= i_pix_data;
   end

   always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // ---- write address and sticky overflow ----
   always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_addr_capture <= '0;
         o_overflow     <= 1'b0;
      end else if (clear_ctx) begin
         o_addr_capture <= '0;
         o_overflow     <= 1'b0;
      end else begin
         if (pop && o_addr_capture != ADDR_MAX) o_addr_capture <= o_addr_capture + 20'd1;
         if (drop) o_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture using a reduced 8x6 window so full frames stay short.
module tb_frame_capture;
   localparam int H = 8;
   localparam int V = 6;

   logic        i_clk_25M, i_rst_n, i_start_capture;
   logic        i_frame_valid, i_line_valid, i_pix_valid, i_wr_ack;
   logic [15:0] i_pix_data;
   logic [19:0] o_addr_capture;
   logic [15:0] o_pixel_value;
   logic        o_wr_req, o_capturing, o_done, o_overflow;

   frame_capture #(.H_ACT(H), .V_ACT(V), .FIFO_DEPTH(4)) dut (
      .i_clk_25M(i_clk_25M), .i_rst_n(i_rst_n), .i_start_capture(i_start_capture),
      .i_frame_valid(i_frame_valid), .i_line_valid(i_line_valid), .i_pix_valid(i_pix_valid),
      .i_pix_data(i_pix_data), .o_addr_capture(o_addr_capture), .o_pixel_value(o_pixel_value),
      .o_wr_req(o_wr_req), .i_wr_ack(i_wr_ack), .o_capturing(o_capturing),
      .o_done(o_done), .o_overflow(o_overflow)
   );

   typedef struct {
      int width; int lines; bit gap; bit ack_thin; bit arm_mid; bit end_same;
      int exp_writes; bit exp_ovf;
   } vec_t;

   int n_pass = 0, n_total = 0;
   int wr_idx = 0, done_cnt = 0, cyc = 0;
   bit ack_auto = 1, ack_thin = 0;
   logic [15:0] pix_val = 16'h0100;
   logic [15:0] exp_q[$];
   logic [15:0] mon_exp;

   initial begin
      i_clk_25M = 0;
      forever #20 i_clk_25M = ~i_clk_25M;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge i_clk_25M);
         #1;
      end
   endtask

   initial begin
      forever begin
         @(posedge i_clk_25M);
         #1;
         cyc++;
         if (ack_auto) i_wr_ack = ack_thin ? (cyc % 3 != 0) : 1'b1;
      end
   end

   // Scoreboard: every accepted write must match the next expected pixel at the next address.
   always @(negedge i_clk_25M) begin
      if (i_rst_n && o_wr_req && i_wr_ack) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL spurious_write: got addr %0d data %0h expected no write", o_addr_capture, o_pixel_value);
         end else begin
            mon_exp = exp_q.pop_front();
            check("wr_addr", 32'(o_addr_capture), 32'(wr_idx));
            check("wr_data", 32'(o_pixel_value), 32'(mon_exp));
            wr_idx++;
         end
      end
      if (i_rst_n && o_done) done_cnt++;
   end

   task automatic pulse_start();
      i_start_capture = 1;
      tick();
      i_start_capture = 0;
   endtask

   task automatic send_frame(input int w, input int l, input bit gap, input bit end_same, input bit record);
      i_frame_valid = 1;
      tick(2);
      for (int y = 0; y < l; y++) begin
         i_line_valid = 1;
         for (int x = 0; x < w; x++) begin
            i_pix_valid = 1;
            i_pix_data  = pix_val;
            if (record && x < H && y < V) exp_q.push_back(pix_val);
            pix_val++;
            tick();
            if (gap) begin
               i_pix_valid = 0;
               tick();
            end
         end
         i_pix_valid = 0;
         if (end_same && y == l - 1) begin
            i_line_valid  = 0;
            i_frame_valid = 0;
            tick();
         end else begin
            i_line_valid = 0;
            tick(3);
         end
      end
      i_frame_valid = 0;
      tick();
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{8, 6, 0, 0, 0, 0, 48, 0};
      vecs[1] = '{10, 8, 0, 0, 0, 0, 48, 0};
      vecs[2] = '{5, 3, 0, 0, 0, 0, 15, 0};
      vecs[3] = '{8, 6, 1, 1, 0, 0, 48, 0};
      vecs[4] = '{8, 6, 0, 0, 1, 0, 48, 0};
      vecs[5] = '{7, 6, 0, 0, 0, 1, 42, 0};

      i_rst_n = 0; i_start_capture = 0; i_frame_valid = 0; i_line_valid = 0;
      i_pix_valid = 0; i_pix_data = 0; i_wr_ack = 1;
      tick(3);
      check("rst_addr", 32'(o_addr_capture), 0);
      check("rst_pix", 32'(o_pixel_value), 0);
      check("rst_wr_req", 32'(o_wr_req), 0);
      check("rst_capturing", 32'(o_capturing), 0);
      check("rst_done", 32'(o_done), 0);
      check("rst_overflow", 32'(o_overflow), 0);
      i_rst_n = 1;
      tick(2);

      for (int i = 0; i < 6; i++) begin
         ack_thin = vecs[i].ack_thin;
         exp_q.delete();
         wr_idx = 0;
         done_cnt = 0;
         if (vecs[i].arm_mid) begin
            i_frame_valid = 1;
            tick(2);
            pulse_start();
            send_frame(4, 2, 0, 0, 0);
            tick(3);
         end else begin
            pulse_start();
            tick(2);
         end
         send_frame(vecs[i].width, vecs[i].lines, vecs[i].gap, vecs[i].end_same, 1);
         tick(60);
         check($sformatf("v%0d_writes", i), 32'(wr_idx), 32'(vecs[i].exp_writes));
         check($sformatf("v%0d_leftover", i), 32'(exp_q.size()), 0);
         check($sformatf("v%0d_done_pulses", i), 32'(done_cnt), 1);
         check($sformatf("v%0d_overflow", i), 32'(o_overflow), 32'(vecs[i].exp_ovf));
         check($sformatf("v%0d_capturing", i), 32'(o_capturing), 0);
      end
      ack_thin = 0;

      // Six-cycle stall from an empty FIFO: four pixels buffer, the fifth and sixth drop.
      exp_q.delete();
      wr_idx = 0;
      done_cnt = 0;
      pulse_start();
      tick(2);
      i_frame_valid = 1;
      tick(2);
      ack_auto = 0;
      i_wr_ack = 0;
      i_line_valid = 1;
      i_pix_valid = 1;
      for (int x = 0; x < 8; x++) begin
         i_pix_data = 16'hA000 + 16'(x);
         if (x != 4 && x != 5) exp_q.push_back(16'hA000 + 16'(x));
         if (x == 6) begin
            i_wr_ack = 1;
            ack_auto = 1;
         end
         tick();
         if (x <= 5) begin
            check("stall_addr", 32'(o_addr_capture), 0);
            check("stall_wr_req", 32'(o_wr_req), 1);
         end
         if (x == 3) check("ovf_before_drop", 32'(o_overflow), 0);
         if (x == 4) check("ovf_at_drop", 32'(o_overflow), 1);
      end
      i_pix_valid = 0;
      i_line_valid = 0;
      tick(3);
      i_frame_valid = 0;
      tick(30);
      check("ovf_writes", 32'(wr_idx), 6);
      check("ovf_done_pulses", 32'(done_cnt), 1);
      check("ovf_sticky", 32'(o_overflow), 1);
      pulse_start();
      check("ovf_cleared", 32'(o_overflow), 0);

      // Reset with three pixels buffered and the arbiter stalled.
      ack_auto = 0;
      i_wr_ack = 0;
      i_frame_valid = 1;
      tick(2);
      i_line_valid = 1;
      i_pix_valid = 1;
      for (int x = 0; x < 3; x++) begin
         i_pix_data = 16'hB000 + 16'(x);
         tick();
      end
      i_pix_valid = 0;
      tick();
      check("pre_rst_wr_req", 32'(o_wr_req), 1);
      check("pre_rst_pix", 32'(o_pixel_value), 32'h0000B000);
      check("pre_rst_capturing", 32'(o_capturing), 1);
      #2 i_rst_n = 0;
      #1;
      check("mid_rst_addr", 32'(o_addr_capture), 0);
      check("mid_rst_pix", 32'(o_pixel_value), 0);
      check("mid_rst_wr_req", 32'(o_wr_req), 0);
      check("mid_rst_capturing", 32'(o_capturing), 0);
      check("mid_rst_done", 32'(o_done), 0);
      check("mid_rst_overflow", 32'(o_overflow), 0);
      tick();
      check("post_rst_wr_req", 32'(o_wr_req), 0);
      i_line_valid = 0;
      i_frame_valid = 0;
      i_rst_n = 1;
      tick(3);
      check("post_rel_wr_req", 32'(o_wr_req), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
